// File: rtl/sr_fifo_bank_pkg.sv
// sr_fifo_bank_pkg: shared defaults and width helpers for the FIFO bank
//   DEF_WIDTH/DEF_DEPTH/DEF_CHANNELS : default geometry used by sr_cpu and the bench
//   cw_of(ch)     : channel-select width, at least 1 bit
//   cnt_bits(dep) : per-channel count field width (AW+1)
package sr_fifo_bank_pkg;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_CHANNELS = 4;
    function automatic int cw_of(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction
    function automatic int cnt_bits(input int dep);
        return $clog2(dep) + 1;
    endfunction
endpackage

// File: rtl/sr_fifo_channel.sv
// sr_fifo_channel: one circular queue with occupancy status and sticky error flags
//   push/din : enqueue request and word      pop/dout : dequeue request and head word
//   full/empty/cnt : registered status       ovf/unf  : sticky overflow/underflow
//   clr      : clears ovf/unf (a coincident new error keeps its flag set)
module sr_fifo_channel #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      cnt,
    output logic             ovf,
    output logic             unf,
    input  logic             clr
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             push_ok, pop_ok;
    always_comb begin
        full    = cnt_q == (AW+1)'(DEPTH);
        empty   = cnt_q == '0;
        pop_ok  = pop & ~empty;
        // a pop on a full queue frees the slot at the same edge
        push_ok = push & (~full | pop);
        wr_d    = wr_q + AW'(push_ok);
        rd_d    = rd_q + AW'(pop_ok);
        cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        ovf_d   = (push & ~push_ok) | (ovf_q & ~clr);
        unf_d   = (pop & empty) | (unf_q & ~clr);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
    always_ff @(posedge clk)
        if (!rst && push_ok) mem_q[wr_q] <= din;
    assign dout = empty ? '0 : mem_q[rd_q];
    assign cnt  = cnt_q;
    assign ovf  = ovf_q;
    assign unf  = unf_q;
endmodule

// File: rtl/sr_fifo_bank.sv
// sr_fifo_bank: CHANNELS independent queues with per-channel status and a popCh-selected head
//   push/pushCh/pushData : enqueue into channel pushCh
//   pop/popCh            : dequeue from channel popCh; popData/popValid combinational
//   full/empty/count     : registered per-channel status, count packed AW+1 bits per channel
//   overflow/underflow   : sticky per-channel error flags, cleared by clrErr
module sr_fifo_bank import sr_fifo_bank_pkg::*; #(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int CHANNELS = DEF_CHANNELS,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = cw_of(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [CW-1:0]                pushCh,
    input  logic [WIDTH-1:0]             pushData,
    input  logic                         pop,
    input  logic [CW-1:0]                popCh,
    output logic [WIDTH-1:0]             popData,
    output logic                         popValid,
    output logic [CHANNELS-1:0]          full,
    output logic [CHANNELS-1:0]          empty,
    output logic [CHANNELS*(AW+1)-1:0]   count,
    output logic [CHANNELS-1:0]          overflow,
    output logic [CHANNELS-1:0]          underflow,
    input  logic                         clrErr
);
    logic [WIDTH-1:0] dout_w [CHANNELS];
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        sr_fifo_channel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch (
            .clk  (clk),
            .rst  (rst),
            .push (push & (pushCh == CW'(c))),
            .pop  (pop & (popCh == CW'(c))),
            .din  (pushData),
            .dout (dout_w[c]),
            .full (full[c]),
            .empty(empty[c]),
            .cnt  (count[c*(AW+1) +: AW+1]),
            .ovf  (overflow[c]),
            .unf  (underflow[c]),
            .clr  (clrErr)
        );
    end
    assign popData  = dout_w[popCh];
    assign popValid = pop & ~empty[popCh];
endmodule

// File: tb/tb_sr_fifo_bank.sv
// tb_sr_fifo_bank: directed vector table plus hand sequences for wrap-around and reset mid-stream
module tb_sr_fifo_bank;
    logic        clk = 1'b0;
    logic        rst, push, pop, clrErr;
    logic [1:0]  pushCh, popCh;
    logic [31:0] pushData, popData;
    logic        popValid;
    logic [3:0]  full, empty, overflow, underflow;
    logic [11:0] count;
    int checks = 0;
    int errors = 0;

    sr_fifo_bank #(.WIDTH(32), .DEPTH(4), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .push(push), .pushCh(pushCh), .pushData(pushData),
        .pop(pop), .popCh(popCh), .popData(popData), .popValid(popValid),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .underflow(underflow), .clrErr(clrErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [1:0]  pch;
        logic [31:0] pd;
        logic        pop;
        logic [1:0]  qch;
        logic        clr;
        logic [31:0] e_pd;
        logic        e_pv;
        logic [11:0] e_cnt;
        logic [3:0]  e_ovf;
        logic [3:0]  e_unf;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    task automatic add(input logic ps, input int pch, input logic [31:0] pd, input logic pp,
                       input int qch, input logic clr, input logic [31:0] epd, input logic epv,
                       input int c0, input int c1, input int c2, input int c3,
                       input logic [3:0] eo, input logic [3:0] eu);
        vec_t v;
        v.push = ps; v.pch = 2'(pch); v.pd = pd; v.pop = pp; v.qch = 2'(qch); v.clr = clr;
        v.e_pd = epd; v.e_pv = epv;
        v.e_cnt = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
        v.e_ovf = eo; v.e_unf = eu;
        tv.push_back(v);
    endtask

    function automatic logic [3:0] sel(input logic [11:0] c, input int val);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = c[i*3 +: 3] == 3'(val);
        return r;
    endfunction

    task automatic drive(input logic r, input logic ps, input logic [1:0] pch, input logic [31:0] pd,
                         input logic pp, input logic [1:0] qch, input logic clr);
        rst = r; push = ps; pushCh = pch; pushData = pd; pop = pp; popCh = qch; clrErr = clr;
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("rst_popData", popData, 32'h0);
        chk("rst_popValid", {31'h0, popValid}, 32'h0);
        chk("rst_empty", {28'h0, empty}, 32'hF);
        chk("rst_full", {28'h0, full}, 32'h0);

        //  push ch data        pop ch clr  e_pd         pv  c0 c1 c2 c3 ovf      unf
        add(0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 32'h11, 0, 0, 0, 32'h00, 0, 1, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 32'h22, 0, 0, 0, 32'h11, 0, 2, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 32'h33, 0, 0, 0, 32'h11, 0, 3, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 32'h44, 0, 0, 0, 32'h11, 0, 4, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 32'h55, 0, 0, 0, 32'h11, 0, 4, 0, 0, 0, 4'b0001, 4'b0000);
        add(0, 0, 32'h00, 1, 0, 0, 32'h11, 1, 3, 0, 0, 0, 4'b0001, 4'b0000);
        add(0, 0, 32'h00, 1, 0, 0, 32'h22, 1, 2, 0, 0, 0, 4'b0001, 4'b0000);
        add(0, 0, 32'h00, 1, 0, 0, 32'h33, 1, 1, 0, 0, 0, 4'b0001, 4'b0000);
        add(0, 0, 32'h00, 1, 0, 0, 32'h44, 1, 0, 0, 0, 0, 4'b0001, 4'b0000);
        add(0, 0, 32'h00, 0, 0, 1, 32'h00, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 32'h11, 0, 1, 0, 32'h00, 0, 1, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 32'h22, 0, 1, 0, 32'h00, 0, 2, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 32'h33, 0, 1, 0, 32'h00, 0, 3, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 32'h44, 0, 1, 0, 32'h00, 0, 4, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 32'hAA, 1, 0, 0, 32'h11, 1, 4, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 1, 32'hBB, 1, 1, 0, 32'h00, 0, 4, 1, 0, 0, 4'b0000, 4'b0010);
        add(0, 0, 32'h00, 0, 1, 1, 32'hBB, 0, 4, 1, 0, 0, 4'b0000, 4'b0000);
        add(0, 0, 32'h00, 1, 2, 1, 32'h00, 0, 4, 1, 0, 0, 4'b0000, 4'b0100);
        add(0, 0, 32'h00, 0, 2, 1, 32'h00, 0, 4, 1, 0, 0, 4'b0000, 4'b0000);
        add(0, 0, 32'h00, 1, 0, 0, 32'h22, 1, 3, 1, 0, 0, 4'b0000, 4'b0000);
        add(0, 0, 32'h00, 1, 0, 0, 32'h33, 1, 2, 1, 0, 0, 4'b0000, 4'b0000);
        add(0, 0, 32'h00, 1, 0, 0, 32'h44, 1, 1, 1, 0, 0, 4'b0000, 4'b0000);
        add(0, 0, 32'h00, 1, 0, 0, 32'hAA, 1, 0, 1, 0, 0, 4'b0000, 4'b0000);
        add(0, 0, 32'h00, 1, 1, 0, 32'hBB, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 32'h01, 0, 0, 0, 32'h00, 0, 1, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 3, 32'h02, 0, 3, 0, 32'h00, 0, 1, 0, 0, 1, 4'b0000, 4'b0000);
        add(0, 0, 32'h00, 1, 3, 0, 32'h02, 1, 1, 0, 0, 0, 4'b0000, 4'b0000);
        add(0, 0, 32'h00, 1, 1, 0, 32'h00, 0, 1, 0, 0, 0, 4'b0000, 4'b0010);
        add(0, 0, 32'h00, 0, 0, 1, 32'h01, 0, 1, 0, 0, 0, 4'b0000, 4'b0000);

        foreach (tv[i]) begin
            @(negedge clk);
            drive(1'b0, tv[i].push, tv[i].pch, tv[i].pd, tv[i].pop, tv[i].qch, tv[i].clr);
            #2;
            chk($sformatf("v%0d_popData", i), popData, tv[i].e_pd);
            chk($sformatf("v%0d_popValid", i), {31'h0, popValid}, {31'h0, tv[i].e_pv});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i), {20'h0, count}, {20'h0, tv[i].e_cnt});
            chk($sformatf("v%0d_full", i), {28'h0, full}, {28'h0, sel(tv[i].e_cnt, 4)});
            chk($sformatf("v%0d_empty", i), {28'h0, empty}, {28'h0, sel(tv[i].e_cnt, 0)});
            chk($sformatf("v%0d_overflow", i), {28'h0, overflow}, {28'h0, tv[i].e_ovf});
            chk($sformatf("v%0d_underflow", i), {28'h0, underflow}, {28'h0, tv[i].e_unf});
        end

        // wrap-around on ch2: each pop returns the word pushed one cycle earlier
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            drive(1'b0, k < 10, 2'd2, 32'h200 + 32'(k), k > 0, 2'd2, 1'b0);
            #2;
            if (k > 0) begin
                chk($sformatf("wrap%0d_popData", k), popData, 32'h200 + 32'(k - 1));
                chk($sformatf("wrap%0d_popValid", k), {31'h0, popValid}, 32'h1);
            end
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d_count2", k), {29'h0, count[8:6]}, (k < 10) ? 32'h1 : 32'h0);
        end
        chk("wrap_underflow", {28'h0, underflow}, 32'h0);

        // reset mid-stream: ch0 holds 0x01, 0x03, 0x04 and ch1 has a sticky underflow
        @(negedge clk); drive(1'b0, 1'b1, 2'd0, 32'h03, 1'b0, 2'd0, 1'b0);
        @(negedge clk); drive(1'b0, 1'b1, 2'd0, 32'h04, 1'b1, 2'd1, 1'b0);
        @(negedge clk); drive(1'b1, 1'b1, 2'd0, 32'h05, 1'b0, 2'd0, 1'b0);
        #1;
        chk("pre_rst_count0", {29'h0, count[2:0]}, 32'h3);
        chk("pre_rst_underflow", {28'h0, underflow}, 32'h2);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("mid_rst_count", {20'h0, count}, 32'h0);
        chk("mid_rst_empty", {28'h0, empty}, 32'hF);
        chk("mid_rst_full", {28'h0, full}, 32'h0);
        chk("mid_rst_flags", {24'h0, overflow, underflow}, 32'h0);
        chk("mid_rst_popData", popData, 32'h0);
        chk("mid_rst_popValid", {31'h0, popValid}, 32'h0);
        @(negedge clk); drive(1'b0, 1'b1, 2'd0, 32'h66, 1'b0, 2'd0, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("post_rst_head", popData, 32'h66);
        chk("post_rst_count0", {29'h0, count[2:0]}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
